// File: rtl/noise_drv_pkg.sv
// noise_drv_pkg: shared types and constants for the noise filter driver.
//   drv_state_t        : handshake FSM states (IDLE, WRITE, WAIT, EMIT)
//   STAT_W             : width of the optional statistics counters
//   DEFAULT_DATA_WIDTH : default sample width, matches the filter
//   sat_add            : saturating add of a small increment to a stat counter
package noise_drv_pkg;

  localparam int unsigned STAT_W             = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT,
    EMIT
  } drv_state_t;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [1:0]        inc);
    logic [STAT_W:0] s;
    s = {1'b0, a} + {{(STAT_W-1){1'b0}}, inc};
    return s[STAT_W] ? '1 : s[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/noise_drv_fifo.sv
// noise_drv_fifo: synchronous first-word fall-through FIFO.
//   clock, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata    : write strobe and data (ignored when full)
//   pop            : consume the head entry (ignored when empty)
//   rdata          : head entry, valid whenever empty=0
//   full, empty    : occupancy flags
//   count          : number of stored entries (AW+1 bits)
module noise_drv_fifo #(
  parameter int unsigned DW = 24,
  parameter int unsigned AW = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int unsigned     DEPTH     = 1 << AW;
  localparam logic [AW:0]     DEPTH_CNT = DEPTH[AW:0];

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noise_filter_driver.sv
// noise_filter_driver: initiator side of the noise filter write/done handshake.
// Buffers upstream samples in a small FIFO, issues one write pulse per sample,
// waits for done (with timeout), and presents the filtered sum downstream.
//   clock, reset_n         : clock, asynchronous active-low reset
//   in_valid/in_data       : upstream sample, accepted when in_ready=1
//   in_ready               : FIFO not full (0 while in reset and until the
//                            first edge after release)
//   flt_write/flt_data     : registered write pulse and sample to the filter
//   flt_done/flt_sum       : filter completion strobe and result
//   out_valid/out_data     : one-cycle strobe with the captured result
//   err_timeout            : sticky, done never arrived for a sample
//   overflow               : sticky, a sample was offered while in_ready=0
// Optional build macro NOISE_DRV_STATS_EN adds saturating 16-bit counters
// stat_samples (results emitted) and stat_drops (overflow drops + timeouts).
module noise_filter_driver
  import noise_drv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  flt_write,
  output logic [DATA_WIDTH-1:0] flt_data,
  input  logic                  flt_done,
  input  logic [DATA_WIDTH-1:0] flt_sum,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  err_timeout,
  output logic                  overflow
`ifdef NOISE_DRV_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_samples,
  output logic [STAT_W-1:0]     stat_drops
`endif
);

  localparam int unsigned      DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = DEPTH[FIFO_AW:0];
  localparam logic [7:0]       TO_LAST   = 8'(TIMEOUT - 1);

  drv_state_t            state;
  logic [7:0]            to_cnt;
  logic                  ready_en;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  got_done;
  logic                  timed_out;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_AW:0]      fifo_count;

  // in_ready is held low through reset and the first edge after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Full is taken from the pre-pop count, so a push racing a pop on a full
  // FIFO is refused rather than accepted.
  assign in_ready  = ready_en & ~fifo_full;
  assign push      = in_valid & in_ready;
  assign drop      = in_valid & ~in_ready;
  assign pop       = (state == IDLE) & ~fifo_empty;
  assign got_done  = (state == WAIT) & flt_done;
  assign timed_out = (state == WAIT) & ~flt_done & (to_cnt == TO_LAST);

  noise_drv_fifo #(
    .DW (DATA_WIDTH),
    .AW (FIFO_AW)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (in_data),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      to_cnt      <= '0;
      flt_write   <= 1'b0;
      flt_data    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            flt_data  <= fifo_rdata;
            flt_write <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          flt_write <= 1'b0;
          to_cnt    <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (got_done) begin
            out_data  <= flt_sum;
            out_valid <= 1'b1;
            state     <= EMIT;
          end else if (timed_out) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        EMIT: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef NOISE_DRV_STATS_EN
  // An overflow drop and a timeout can land on the same edge: count both.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_samples <= '0;
      stat_drops   <= '0;
    end else begin
      stat_samples <= sat_add(stat_samples, {1'b0, got_done});
      stat_drops   <= sat_add(stat_drops, {1'b0, drop} + {1'b0, timed_out});
    end
  end
`else
  // Statistics counters not built.
`endif

  // Occupancy flags and count must stay consistent.
  a_fifo_full_cnt: assert property (@(posedge clock) disable iff (!reset_n)
    fifo_full == (fifo_count == DEPTH_CNT));

endmodule

// File: tb/tb_noise_filter_driver.sv
module tb_noise_filter_driver;

  localparam int DW    = 24;
  localparam int AW    = 2;
  localparam int TO    = 15;
  localparam int DEPTH = 1 << AW;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          flt_done = 1'b0;
  logic [DW-1:0] flt_sum  = '0;
  logic          in_ready;
  logic          flt_write;
  logic [DW-1:0] flt_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          err_timeout;
  logic          overflow;
`ifdef NOISE_DRV_STATS_EN
  logic [15:0]   stat_samples;
  logic [15:0]   stat_drops;
`endif

  noise_filter_driver #(
    .DATA_WIDTH (DW),
    .FIFO_AW    (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .flt_write   (flt_write),
    .flt_data    (flt_data),
    .flt_done    (flt_done),
    .flt_sum     (flt_sum),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .err_timeout (err_timeout),
`ifdef NOISE_DRV_STATS_EN
    .stat_samples(stat_samples),
    .stat_drops  (stat_drops),
`endif
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clock);
  endtask

  // ---------------- behavioural reference model ----------------
  // Time-based view: a write at edge w_edge occupies the filter; done is
  // accepted at edges w_edge+2 .. w_edge+1+TO, else the sample is abandoned.
  logic [DW-1:0] q[$];
  bit            m_started = 0;
  bit            m_inflight = 0;
  int            n_edge = 0;
  int            w_edge = 0;
  int            free_at = 0;
  int            rel;
  bit            rdy;
  bit            m_write = 0;
  logic [DW-1:0] m_fdata = '0;
  bit            m_valid = 0;
  logic [DW-1:0] m_odata = '0;
  bit            m_err = 0;
  bit            m_ovf = 0;
  int            m_samples = 0;
  int            m_drops = 0;

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        q.delete();
        m_started = 0; m_inflight = 0; free_at = 0;
        m_write = 0; m_fdata = '0; m_valid = 0; m_odata = '0;
        m_err = 0; m_ovf = 0; m_samples = 0; m_drops = 0;
      end else begin
        n_edge++;
        rdy = m_started && (q.size() < DEPTH);
        m_valid = 0;
        m_write = 0;
        if (m_inflight) begin
          rel = n_edge - w_edge;
          if (rel >= 2 && rel <= TO + 1) begin
            if (flt_done) begin
              m_odata = flt_sum; m_valid = 1; m_inflight = 0; free_at = n_edge + 2;
              if (m_samples < 65535) m_samples++;
            end else if (rel == TO + 1) begin
              m_err = 1; m_inflight = 0; free_at = n_edge + 1;
              if (m_drops < 65535) m_drops++;
            end
          end
        end else if (n_edge >= free_at && q.size() > 0) begin
          w_edge = n_edge; m_inflight = 1; m_write = 1; m_fdata = q.pop_front();
        end
        if (in_valid) begin
          if (rdy) q.push_back(in_data);
          else begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
          end
        end
        m_started = 1;
      end
    end
  end

  // ---------------- filter responder ----------------
  int            resp_mode = 0;  // 0: done 1 cycle after write, 1: never, 2: random
  int            countdown = 0;
  logic [DW-1:0] pend = '0;
  bit            spur_req = 0;

  initial begin
    forever begin
      @(negedge clock);
      flt_done = 1'b0;
      if (!reset_n) begin
        countdown = 0;
      end else begin
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            flt_done = 1'b1;
            flt_sum  = pend >> 3;
          end
        end
        if (flt_write) begin
          pend = flt_data;
          case (resp_mode)
            0:       countdown = 1;
            1:       countdown = 0;
            default: countdown = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO + 2));
          endcase
        end
        if (spur_req) begin
          flt_done = 1'b1;
          flt_sum  = 24'hABCDEF;
          spur_req = 0;
        end
      end
    end
  end

  // ---------------- monitor + per-cycle compare ----------------
  bit            cmp_en = 0;
  logic [DW-1:0] wr_log[$];
  time           wr_time[$];
  logic [DW-1:0] out_log[$];
  time           err_time = 0;
  bit            err_prev = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        if (flt_write) begin wr_log.push_back(flt_data); wr_time.push_back($time); end
        if (out_valid) out_log.push_back(out_data);
        if (err_timeout && !err_prev) err_time = $time;
        err_prev = err_timeout;
        chk("in_ready",    {31'd0, in_ready},    {31'd0, m_started && (q.size() < DEPTH)});
        chk("flt_write",   {31'd0, flt_write},   {31'd0, m_write});
        chk("flt_data",    {8'd0, flt_data},     {8'd0, m_fdata});
        chk("out_valid",   {31'd0, out_valid},   {31'd0, m_valid});
        chk("out_data",    {8'd0, out_data},     {8'd0, m_odata});
        chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
        chk("overflow",    {31'd0, overflow},    {31'd0, m_ovf});
`ifdef NOISE_DRV_STATS_EN
        chk("stat_samples", {16'd0, stat_samples}, 32'(m_samples));
        chk("stat_drops",   {16'd0, stat_drops},   32'(m_drops));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [5:0]    wv, ov;
  bit            any_valid;
  bit            rdy5, rdy6;
  logic [DW-1:0] v;

  initial begin
    #1 reset_n = 1'b0;
    cmp_en = 1;
    cyc(3);
    #2 reset_n = 1'b1;
    cyc(2);

    // Single sample: latency and pulse widths.
    resp_mode = 0;
    @(negedge clock); in_valid = 1'b1; in_data = 24'h000100;
    @(negedge clock); in_valid = 1'b0;
    wv = '0; ov = '0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      wv[i] = flt_write;
      ov[i] = out_valid;
    end
    chk("single_write_pulse", {26'd0, wv}, 32'h02);
    chk("single_valid_pulse", {26'd0, ov}, 32'h08);
    chk("single_flt_data", {8'd0, flt_data}, 32'h000100);
    chk("single_out_data", {8'd0, out_data}, 32'h000020);

    // Spurious done while idle.
    cyc(2);
    spur_req = 1;
    any_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      any_valid |= out_valid;
    end
    chk("spurious_out_data", {8'd0, out_data}, 32'h000020);
    chk("spurious_out_valid", {31'd0, any_valid}, 32'd0);

    // Burst of 6 back-to-back samples.
    wr_log.delete(); wr_time.delete();
    rdy5 = 0; rdy6 = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (i == 5) rdy5 = in_ready;
      if (i == 6) rdy6 = in_ready;
      in_valid = 1'b1;
      in_data  = DW'(i);
    end
    @(negedge clock); in_valid = 1'b0;
    cyc(25);
    chk("burst_ready_before_5", {31'd0, rdy5}, 32'd1);
    chk("burst_ready_full", {31'd0, rdy6}, 32'd0);
    chk("burst_overflow", {31'd0, overflow}, 32'd1);
    chk("burst_write_count", wr_log.size(), 32'd5);
    for (int i = 0; i < wr_log.size() && i < 5; i++)
      chk("burst_order", {8'd0, wr_log[i]}, 32'(i + 1));
    for (int i = 1; i < wr_time.size(); i++)
      chk("burst_spacing", 32'(wr_time[i] - wr_time[i-1]), 32'd40);
`ifdef NOISE_DRV_STATS_EN
    chk("burst_stat_drops", {16'd0, stat_drops}, 32'd1);
`endif

    // Filter never answers: timeout.
    resp_mode = 1;
    wr_log.delete(); wr_time.delete(); out_log.delete(); err_time = 0;
    @(negedge clock); in_valid = 1'b1; in_data = 24'h111111;
    @(negedge clock); in_data = 24'h222222;
    @(negedge clock); in_valid = 1'b0;
    cyc(3 * TO + 10);
    chk("timeout_write_seen", {31'd0, wr_time.size() > 0}, 32'd1);
    if (wr_time.size() > 0)
      chk("timeout_latency", 32'((err_time - wr_time[0]) / 10 - 1), 32'(TO));
    chk("timeout_next_written", wr_log.size(), 32'd2);
    if (wr_log.size() == 2)
      chk("timeout_next_data", {8'd0, wr_log[1]}, 32'h222222);
    chk("timeout_no_out_valid", out_log.size(), 32'd0);

    // Reset asserted while waiting with samples queued.
    @(negedge clock); in_valid = 1'b1; in_data = 24'h0A0001;
    @(negedge clock); in_data = 24'h0A0002;
    @(negedge clock); in_data = 24'h0A0003;
    @(negedge clock); in_valid = 1'b0;
    cyc(1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_in_ready",    {31'd0, in_ready},    32'd0);
    chk("rst_flt_write",   {31'd0, flt_write},   32'd0);
    chk("rst_flt_data",    {8'd0, flt_data},     32'd0);
    chk("rst_out_valid",   {31'd0, out_valid},   32'd0);
    chk("rst_out_data",    {8'd0, out_data},     32'd0);
    chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    chk("rst_overflow",    {31'd0, overflow},    32'd0);
    cyc(2);
    wr_log.delete(); out_log.delete();
    #2 reset_n = 1'b1;
    @(negedge clock); spur_req = 1;
    cyc(10);
    chk("rst_fifo_empty", wr_log.size(), 32'd0);
    chk("rst_late_done_ignored", out_log.size(), 32'd0);
    chk("rst_out_data_after", {8'd0, out_data}, 32'd0);
    chk("rst_in_ready_after", {31'd0, in_ready}, 32'd1);

    // Pointer wrap: 10 samples at one per 4 cycles.
    resp_mode = 0;
    wr_log.delete(); out_log.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); in_valid = 1'b1; in_data = DW'(32'h1000 + i * 32'h108);
      @(negedge clock); in_valid = 1'b0;
      cyc(2);
    end
    cyc(10);
    chk("wrap_write_count", wr_log.size(), 32'd10);
    chk("wrap_out_count", out_log.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      v = DW'(32'h1000 + i * 32'h108);
      if (i < wr_log.size())  chk("wrap_write_order", {8'd0, wr_log[i]}, {8'd0, v});
      if (i < out_log.size()) chk("wrap_out_order", {8'd0, out_log[i]}, {8'd0, v >> 3});
    end
    chk("wrap_no_overflow", {31'd0, overflow}, 32'd0);
    chk("wrap_no_timeout", {31'd0, err_timeout}, 32'd0);

    // Randomized traffic with random filter latency and spurious dones.
    resp_mode = 2;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = DW'($urandom);
      if ($urandom_range(0, 15) == 0) spur_req = 1;
    end
    @(negedge clock); in_valid = 1'b0;
    cyc(3 * TO + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
